// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multicycle controller: FSM states,
//               opcodes, datapath select codes and the control-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // 4-bit state encodings; values 12..15 are unused and recover to fetch
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11
  } state_e;

  // Supported opcodes
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] c_srcb_reg   = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  // PC source select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // Raw control word produced by the state decode (before reset gating)
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // True for every opcode the controller knows how to execute
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == c_op_lw)    || (op == c_op_sw)   ||
           (op == c_op_rtype) || (op == c_op_beq)  ||
           (op == c_op_addi)  || (op == c_op_j);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_if
// Description : Controller <-> datapath bundle. The master modport is the
//               controller side, the slave modport the datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       pcen;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output memread, memwrite, irwrite, regwrite, pcen,
    output iord, alusrca, regdst, memtoreg,
    output alusrcb, pcsrc, aluop, illegal_op, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  memread, memwrite, irwrite, regwrite, pcen,
    input  iord, alusrca, regdst, memtoreg,
    input  alusrcb, pcsrc, aluop, illegal_op, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_outdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_outdec
// Description : Combinational state-to-control decode. Everything not named
//               for a state is driven 0; unused encodings decode to all-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_outdec
  import mc_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  // Per-state control word; fetch commits IR/PC only in the ready cycle
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    unique case (i_state)
      ST_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = c_srcb_four;
        o_ctrl.aluop   = c_aluop_add;
        o_ctrl.pcsrc   = c_pcsrc_alu;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alusrcb = c_srcb_immsh;
        o_ctrl.aluop   = c_aluop_add;
        o_illegal      = ~is_legal_op(i_op);
      end
      ST_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = c_srcb_imm;
        o_ctrl.aluop   = c_aluop_add;
      end
      ST_MEMRD: begin
        o_ctrl.iord    = 1'b1;
        o_ctrl.memread = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      ST_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      ST_RTYPEEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = c_srcb_reg;
        o_ctrl.aluop   = c_aluop_funct;
      end
      ST_RTYPEWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      ST_BEQEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = c_srcb_reg;
        o_ctrl.aluop   = c_aluop_sub;
        o_ctrl.pcsrc   = c_pcsrc_aluout;
        o_ctrl.branch  = 1'b1;
      end
      ST_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = c_srcb_imm;
        o_ctrl.aluop   = c_aluop_add;
      end
      ST_ADDIWB: begin
        o_ctrl.regwrite = 1'b1;
      end
      ST_JEX: begin
        o_ctrl.pcsrc   = c_pcsrc_jump;
        o_ctrl.pcwrite = 1'b1;
      end
      default: begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle CPU control FSM (Moore). Holds the state register
//               and next-state logic; output decode lives in mc_outdec.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  mc_if.master   bus
);

  state_e r_state;
  state_e w_next_state;
  logic   w_mem_ready;
  ctrl_t  w_ctrl;
  logic   w_illegal;

  // Without a handshake every memory access completes in its first cycle
  assign w_mem_ready = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // State register; reset drops straight to fetch without a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; unknown encodings recover to fetch
  always_comb begin
    w_next_state = ST_FETCH;
    unique case (r_state)
      ST_FETCH:   w_next_state = w_mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          c_op_lw, c_op_sw: w_next_state = ST_MEMADR;
          c_op_rtype:       w_next_state = ST_RTYPEEX;
          c_op_beq:         w_next_state = ST_BEQEX;
          c_op_addi:        w_next_state = ST_ADDIEX;
          c_op_j:           w_next_state = ST_JEX;
          default:          w_next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR:  w_next_state = (bus.op == c_op_lw) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   w_next_state = w_mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:   w_next_state = ST_FETCH;
      ST_MEMWR:   w_next_state = w_mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTYPEEX: w_next_state = ST_RTYPEWB;
      ST_RTYPEWB: w_next_state = ST_FETCH;
      ST_BEQEX:   w_next_state = ST_FETCH;
      ST_ADDIEX:  w_next_state = ST_ADDIWB;
      ST_ADDIWB:  w_next_state = ST_FETCH;
      ST_JEX:     w_next_state = ST_FETCH;
      default:    w_next_state = ST_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (w_mem_ready),
    .i_op        (bus.op),
    .o_ctrl      (w_ctrl),
    .o_illegal   (w_illegal)
  );

  // Strobes are masked while reset is low so nothing writes after reset
  // asserts; selects pass through and show the fetch values during reset.
  assign bus.memread    = w_ctrl.memread  & reset_n;
  assign bus.memwrite   = w_ctrl.memwrite & reset_n;
  assign bus.irwrite    = w_ctrl.irwrite  & reset_n;
  assign bus.regwrite   = w_ctrl.regwrite & reset_n;
  assign bus.pcen       = (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero)) & reset_n;
  assign bus.illegal_op = w_illegal & reset_n;
  assign bus.iord       = w_ctrl.iord;
  assign bus.alusrca    = w_ctrl.alusrca;
  assign bus.regdst     = w_ctrl.regdst;
  assign bus.memtoreg   = w_ctrl.memtoreg;
  assign bus.alusrcb    = w_ctrl.alusrcb;
  assign bus.pcsrc      = w_ctrl.pcsrc;
  assign bus.aluop      = w_ctrl.aluop;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Randomized instruction-level bench for mc_controller with a
//               per-instruction reference model (cycles and strobe counts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;
  import mc_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  mc_if bus1();
  mc_if bus0();

  mc_controller #(.MEM_HANDSHAKE(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.master)
  );

  mc_controller #(.MEM_HANDSHAKE(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Runs one instruction on the handshake DUT from a fetch state. The memory
  // answers the fetch after fw wait cycles and the data access after mw.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int fw, input int mw, input string tag);
    int   cyc = 0, rw = 0, mwc = 0, pc = 0, il = 0, af = 0, ir = 0;
    int   ec, erw, emw, epc, eil, eaf;
    int   acc = 0, cnt = 0;
    int   waits[2];
    bit   left = 0, done = 0;
    logic req, rdy;
    waits[0] = fw;
    waits[1] = mw;
    bus1.op   = op;
    bus1.zero = z;
    while (!done && cyc < 40) begin
      if (left && bus1.state == 4'd0) begin
        done = 1;
      end else begin
        req = bus1.memread | bus1.memwrite;
        rdy = req && (acc < 2) && (cnt == waits[acc]);
        bus1.mem_ready = rdy;
        #1;
        rw  += int'(bus1.regwrite);
        mwc += int'(bus1.memwrite);
        pc  += int'(bus1.pcen);
        il  += int'(bus1.illegal_op);
        ir  += int'(bus1.irwrite);
        af  += int'(bus1.aluop == 2'b10);
        if (bus1.state != 4'd0) left = 1;
        cyc++;
        if (rdy) begin
          acc++;
          cnt = 0;
        end else if (req) begin
          cnt++;
        end
        @(negedge clk);
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
    // Reference: instruction-level cost and strobe counts
    erw = 0; emw = 0; epc = 1; eil = 0; eaf = 0;
    case (op)
      6'b100011: begin ec = 5 + fw + mw; erw = 1; end
      6'b101011: begin ec = 4 + fw + mw; emw = 1 + mw; end
      6'b000000: begin ec = 4 + fw; erw = 1; eaf = 1; end
      6'b001000: begin ec = 4 + fw; erw = 1; end
      6'b000100: begin ec = 3 + fw; epc = 1 + int'(z); end
      6'b000010: begin ec = 3 + fw; epc = 2; end
      default:   begin ec = 2 + fw; eil = 1; end
    endcase
    chk({tag, "_cycles"},   cyc, ec);
    chk({tag, "_regwrite"}, rw,  erw);
    chk({tag, "_memwrite"}, mwc, emw);
    chk({tag, "_pcen"},     pc,  epc);
    chk({tag, "_illegal"},  il,  eil);
    chk({tag, "_irwrite"},  ir,  1);
    chk({tag, "_funct"},    af,  eaf);
  endtask

  function automatic logic [5:0] pick_op(input int k);
    logic [5:0] legal[6];
    logic [5:0] o;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    if (k < 6) return legal[k];
    o = 6'b111111;
    for (int t = 0; t < 8; t++) begin
      o = 6'($urandom_range(0, 63));
      if (!(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}))
        break;
      o = 6'b111111;
    end
    return o;
  endfunction

  initial begin
    logic [5:0] seq[4];
    int idx, cyc, af, rw, mwc, pc;
    bit left;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus1.op = 6'd0; bus1.zero = 1'b0; bus1.mem_ready = 1'b1;
    bus0.op = 6'd0; bus0.zero = 1'b0; bus0.mem_ready = 1'b0;

    // Reset state: fetch, strobes low even with mem_ready high
    #1;
    chk("rst_state",   bus1.state, 4'd0);
    chk("rst_memread", bus1.memread, 1'b0);
    chk("rst_irwrite", bus1.irwrite, 1'b0);
    chk("rst_pcen",    bus1.pcen, 1'b0);
    chk("rst_alusrcb", bus1.alusrcb, 2'b01);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_state", bus1.state, 4'd0);

    // Release; no-handshake DUT runs R, addi, sw, j from the first edge
    bus1.mem_ready = 1'b0;
    seq = '{6'b000000, 6'b001000, 6'b101011, 6'b000010};
    reset_n = 1'b1;
    idx = 0; cyc = 0; af = 0; rw = 0; mwc = 0; pc = 0; left = 0;
    bus0.op = seq[0];
    while (idx < 4 && cyc < 40) begin
      #1;
      if (left && bus0.state == 4'd0) begin
        idx++;
        left = 0;
        if (idx < 4) bus0.op = seq[idx];
      end
      if (idx < 4) begin
        af  += int'(bus0.aluop == 2'b10);
        rw  += int'(bus0.regwrite);
        mwc += int'(bus0.memwrite);
        pc  += int'(bus0.pcen);
        if (bus0.state != 4'd0) left = 1;
        cyc++;
        @(negedge clk);
      end
    end
    chk("nohs_cycles",   cyc, 15);
    chk("nohs_funct",    af, 1);
    chk("nohs_regwrite", rw, 2);
    chk("nohs_memwrite", mwc, 1);
    chk("nohs_pcen",     pc, 5);
    chk("stall_state",   bus1.state, 4'd0);

    // Directed corner cases
    run_instr(6'b100011, 1'b0, 0, 3, "lw_wait3");
    run_instr(6'b000100, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 1'b0, 0, 0, "beq_nottaken");
    run_instr(6'b111111, 1'b0, 0, 0, "illegal");
    run_instr(6'b101011, 1'b0, 1, 2, "sw_wait");

    // Reset in the middle of R-type writeback
    bus1.op = 6'b000000;
    bus1.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rtwb_regwrite", bus1.regwrite, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_regwrite", bus1.regwrite, 1'b0);
    chk("midrst_state",    bus1.state, 4'd0);
    chk("midrst_memread",  bus1.memread, 1'b0);
    chk("midrst_irwrite",  bus1.irwrite, 1'b0);
    @(negedge clk);
    #1;
    chk("midrst_hold_state", bus1.state, 4'd0);
    chk("midrst_hold_pcen",  bus1.pcen, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("resume_memread", bus1.memread, 1'b1);
    chk("resume_irwrite", bus1.irwrite, 1'b1);
    run_instr(6'b001000, 1'b0, 0, 0, "resume_addi");

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      run_instr(pick_op($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    // Unused encoding recovers to fetch on the next edge
    bus1.mem_ready = 1'b0;
    force dut.r_state = state_e'(4'hF);
    #1;
    chk("unused_state",   bus1.state, 4'hF);
    chk("unused_memread", bus1.memread, 1'b0);
    release dut.r_state;
    @(posedge clk);
    #1;
    chk("unused_recover", bus1.state, 4'd0);
    @(negedge clk);
    run_instr(6'b000010, 1'b0, 0, 0, "after_unused_j");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1: when 1, memory states wait on mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  6  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 memread, memwrite, irwrite, regwrite, pcen  out  1 each  datapath strobes.
REQ-008 iord, alusrca, regdst, memtoreg  out  1 each  datapath mux selects.
REQ-009 alusrcb  out  2  ALU B-select: 00 reg, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-010 pcsrc  out  2  PC source: 00 ALU result, 01 ALU-out register, 10 jump target.
REQ-011 aluop  out  2  00 add, 01 subtract, 10 decode funct field.
REQ-012 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-013 state  out  4  current state, for debug.

Function
REQ-014 Moore FSM; any output not listed for a state SHALL be 0.
REQ-015 pcen SHALL equal pcwrite | (branch & zero); pcwrite and branch are internal.
REQ-016 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. When mem_ready=1: irwrite=1, pcwrite=1, next state DECODE. Otherwise stay in FETCH with irwrite=pcwrite=0.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other -> FETCH, with illegal_op=1 for that cycle.
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state MEMRD if op=100011, else MEMWR.
REQ-019 MEMRD: iord=1, memread=1. Go to MEMWB on mem_ready, else hold.
REQ-020 MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
REQ-021 MEMWR: iord=1. memwrite=1 while waiting and in the ready cycle. Go to FETCH on mem_ready, else hold.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next state RTYPEWB.
REQ-023 RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
REQ-024 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state FETCH.
REQ-025 ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
REQ-026 ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
REQ-027 JEX: pcsrc=10, pcwrite=1. Next state FETCH.
REQ-028 Instruction cycle counts with no wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-029 Unused state encodings SHALL go to FETCH on the next edge.

Reset
REQ-030 reset_n low SHALL force state=FETCH immediately, without waiting for a clock edge.
REQ-031 While reset_n is low, all strobes (memread, memwrite, irwrite, regwrite, pcen, illegal_op) SHALL be 0. Selects take their FETCH values.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction; no write strobe may fire after reset asserts.
REQ-033 The first fetch SHALL occur on the first rising edge with reset_n high.

Structure
REQ-034 Shared package mc_pkg SHALL hold the state encodings (4-bit), opcode constants, and aluop/alusrcb/pcsrc constants.
REQ-035 One sub-module, mc_outdec, SHALL hold the combinational state-to-control decode. The FSM register and next-state logic stay in mc_controller.

Verification
REQ-036 Reset mid-RTYPEWB -> regwrite=0 during reset; state=FETCH; normal fetch resumes after release.
REQ-037 lw with mem_ready held low 3 cycles in MEMRD -> state stays MEMRD 3 extra cycles; regwrite=1 exactly once, in MEMWB; total 8 cycles.
REQ-038 beq with zero=1 -> pcen=1 in BEQEX; with zero=0 -> pcen=0; each returns to FETCH after 3 cycles.
REQ-039 op=111111 -> illegal_op high for exactly 1 cycle in DECODE; state returns to FETCH; no write strobes.
REQ-040 Sequence R-type, addi, sw, j with MEM_HANDSHAKE=0 -> 4+4+4+3=15 cycles; aluop is 10 only in RTYPEEX.
REQ-041 Force an unused state encoding -> FETCH on the next edge.
